e_mdu_ctrl: RTL and testbench

- E-stage multiply/divide sequencer; sits beside the E-stage ALU in the P7 pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo and models the multi-cycle latency of the multiplier/divider with a busy counter.
- Owns the architectural HI/LO registers.
- Generates the D-stage stall request and honours exception/interrupt cancellation so a flushed instruction never modifies HI/LO.

---
 rtl/e_mdu_ctrl.sv | 125 ++++++++++++
 tb/tb_e_mdu_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models MULT/DIV latency with a busy counter,
// and raises the D-stage stall while an operation is launching or in flight.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  MDUop,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        start,
  input  logic        req_cancel,
  input  logic        D_MDUuse,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic [31:0]    r_hi_n;
  logic [31:0]    r_lo_n;
  logic           r_commit;

  logic               w_md_op;
  logic               w_is_div;
  logic               w_launch;
  logic               w_ovf;
  logic [31:0]        w_sdivb;
  logic [31:0]        w_udivb;
  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquo;
  logic [31:0]        w_urem;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;

  assign w_md_op  = (MDUop >= 4'd1) && (MDUop <= 4'd4);
  assign w_is_div = (MDUop == 4'd3) || (MDUop == 4'd4);
  assign w_launch = start & ~req_cancel & (MDUop >= 4'd1) & (MDUop <= 4'd6);

  // Zero divisors and the signed overflow case divide by 1 instead; the zero case never commits,
  // and MIN/1 already yields the required quotient 0x80000000 with remainder 0.
  assign w_ovf   = (dataA == 32'h8000_0000) && (dataB == 32'hFFFF_FFFF);
  assign w_sdivb = ((dataB == 32'd0) || w_ovf) ? 32'd1 : dataB;
  assign w_udivb = (dataB == 32'd0) ? 32'd1 : dataB;

  assign w_sprod = $signed({{32{dataA[31]}}, dataA}) * $signed({{32{dataB[31]}}, dataB});
  assign w_uprod = {32'd0, dataA} * {32'd0, dataB};
  assign w_squo  = $signed(dataA) / $signed(w_sdivb);
  assign w_srem  = $signed(dataA) % $signed(w_sdivb);
  assign w_uquo  = dataA / w_udivb;
  assign w_urem  = dataA % w_udivb;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (MDUop)
      4'd1: begin w_res_hi = w_sprod[63:32]; w_res_lo = w_sprod[31:0]; end
      4'd2: begin w_res_hi = w_uprod[63:32]; w_res_lo = w_uprod[31:0]; end
      4'd3: begin w_res_hi = w_srem;         w_res_lo = w_squo;        end
      4'd4: begin w_res_hi = w_urem;         w_res_lo = w_uquo;        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_n   <= 32'd0;
      r_lo_n   <= 32'd0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            if (w_md_op) begin
              r_hi_n   <= w_res_hi;
              r_lo_n   <= w_res_lo;
              r_commit <= !(w_is_div && (dataB == 32'd0));
              r_cnt    <= (MDUop <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              r_state  <= S_BUSY;
            end else if (MDUop == 4'd5) begin
              r_hi <= dataA;
            end else begin
              r_lo <= dataA;
            end
          end
        end
        S_BUSY: begin
          // Launches and cancels arriving here are ignored; the operation always runs to completion.
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            if (r_commit) begin
              r_hi <= r_hi_n;
              r_lo <= r_lo_n;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_BUSY);
  assign stall = D_MDUuse & (busy | (start & ~req_cancel & w_md_op));
  assign HI    = r_hi;
  assign LO    = r_lo;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: directed and random ops checked against a 64-bit arithmetic model of HI/LO
// plus busy-window length, stall and cancel/reset behaviour.
module tb_e_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  MDUop = 4'd0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic        start = 1'b0;
  logic        req_cancel = 1'b0;
  logic        D_MDUuse = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .MDUop(MDUop), .dataA(dataA), .dataB(dataB),
    .start(start), .req_cancel(req_cancel), .D_MDUuse(D_MDUuse),
    .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI,LO} from plain 64-bit arithmetic on the current model state.
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    logic [31:0]     q, rm;
    r  = {m_hi, m_lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: r = 64'(sa * sb);
      4'd2: r = ua * ub;
      4'd3: if (b != 32'd0) begin q = 32'(sa / sb); rm = 32'(sa % sb); r = {rm, q}; end
      4'd4: if (b != 32'd0) begin q = a / b; rm = a % b; r = {rm, q}; end
      4'd5: r[63:32] = a;
      4'd6: r[31:0] = a;
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic d_use, input int cancel_at, input bit junk);
    logic [63:0] exp;
    int          n;
    int          want;
    bit          md;
    md  = (op >= 4'd1) && (op <= 4'd4);
    exp = ref_res(op, a, b);
    MDUop = op; dataA = a; dataB = b; start = 1'b1; req_cancel = 1'b0; D_MDUuse = d_use;
    #1;
    chk("stall_launch", {31'd0, stall}, {31'd0, d_use & md});
    tick();
    start = 1'b0; MDUop = 4'd0; dataA = $urandom; dataB = $urandom;
    if (md) begin
      want = (op <= 4'd2) ? MC : DC;
      n = 0;
      while (busy === 1'b1 && n < 64) begin
        n++;
        req_cancel = (n == cancel_at);
        if (junk && n == 2) begin start = 1'b1; MDUop = 4'd5; end
        else begin start = 1'b0; MDUop = 4'd0; end
        #1;
        chk("stall_busy", {31'd0, stall}, {31'd0, d_use});
        chk("hi_hold", HI, m_hi);
        chk("lo_hold", LO, m_lo);
        tick();
      end
      req_cancel = 1'b0; start = 1'b0; MDUop = 4'd0;
      chk("busy_len", n, want);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    chk("busy_after", {31'd0, busy}, 32'd0);
    D_MDUuse = 1'b0;
    #1;
    chk("stall_idle", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    #10 reset_n = 1'b1;
    tick();

    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 0, 1'b0);
    chk("mult_hi_k", HI, 32'hFFFF_FFFF);
    chk("mult_lo_k", LO, 32'hFFFF_FFFA);

    do_op(4'd4, 32'd100, 32'd7, 1'b0, 0, 1'b1);
    chk("divu_lo_k", LO, 32'd14);
    chk("divu_hi_k", HI, 32'd2);

    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
    chk("div_lo_k", LO, 32'hFFFF_FFFD);
    chk("div_hi_k", HI, 32'hFFFF_FFFF);

    do_op(4'd6, 32'h1234, 32'd0, 1'b1, 0, 1'b0);
    do_op(4'd5, 32'h5678, 32'd0, 1'b1, 0, 1'b0);
    do_op(4'd3, 32'd5, 32'd0, 1'b1, 0, 1'b0);
    chk("div0_hi_k", HI, 32'h5678);
    chk("div0_lo_k", LO, 32'h1234);
    do_op(4'd4, 32'hFFFF_0000, 32'd0, 1'b0, 0, 1'b0);

    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    chk("ovf_lo_k", LO, 32'h8000_0000);
    chk("ovf_hi_k", HI, 32'd0);

    // Launch killed by req_cancel in the same cycle.
    MDUop = 4'd1; dataA = 32'h0001_0000; dataB = 32'h0001_0000;
    start = 1'b1; req_cancel = 1'b1; D_MDUuse = 1'b1;
    #1;
    chk("cancel_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; req_cancel = 1'b0; MDUop = 4'd0; D_MDUuse = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", HI, m_hi);
    chk("cancel_lo", LO, m_lo);

    do_op(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 3, 1'b0);
    do_op(4'd9, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 8));
      if (rop > 4'd6) rop = 4'($urandom_range(7, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {{28{rb[31]}}, rb[3:0]};
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    end

    // Reset in cycle 4 of a divide aborts it immediately.
    MDUop = 4'd4; dataA = 32'd1000; dataB = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; MDUop = 4'd0;
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    #2 reset_n = 1'b1;
    tick();
    do_op(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 0, 1'b0);
    chk("mthi_k", HI, 32'hDEAD_BEEF);
    chk("mthi_lo_k", LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
